// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - four-master round-robin bus arbiter with active-low request/grant
module bus_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic m0_req_,
  input  logic m1_req_,
  input  logic m2_req_,
  input  logic m3_req_,
  output logic m0_grnt_,
  output logic m1_grnt_,
  output logic m2_grnt_,
  output logic m3_grnt_
);

  // Current bus owner; master 0 owns the bus out of reset even when idle.
  logic [1:0] r_owner;

  // Requests flipped to active-high so the search logic reads naturally.
  logic [3:0] w_req;
  // The three challengers in round-robin order; 2-bit adds wrap 3 -> 0.
  logic [1:0] w_cand1;
  logic [1:0] w_cand2;
  logic [1:0] w_cand3;
  logic [1:0] w_next_owner;

  assign w_req   = ~{m3_req_, m2_req_, m1_req_, m0_req_};
  assign w_cand1 = r_owner + 2'd1;
  assign w_cand2 = r_owner + 2'd2;
  assign w_cand3 = r_owner + 2'd3;

  // Owner keeps the bus while requesting; otherwise the first requester after it wins.
  // With nobody requesting the grant parks on the current owner.
  always_comb begin
    w_next_owner = r_owner;
    if (w_req[r_owner]) begin
      w_next_owner = r_owner;
    end else if (w_req[w_cand1]) begin
      w_next_owner = w_cand1;
    end else if (w_req[w_cand2]) begin
      w_next_owner = w_cand2;
    end else if (w_req[w_cand3]) begin
      w_next_owner = w_cand3;
    end
  end

  // Owner register; reset is asynchronous so grants snap back to master 0 immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_owner <= 2'd0;
    end else begin
      r_owner <= w_next_owner;
    end
  end

  // Grant decode straight from the owner register gives exactly one low grant.
  assign m0_grnt_ = (r_owner != 2'd0);
  assign m1_grnt_ = (r_owner != 2'd1);
  assign m2_grnt_ = (r_owner != 2'd2);
  assign m3_grnt_ = (r_owner != 2'd3);

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized and directed checks of bus_arbiter against a round-robin model
module tb_bus_arbiter;

  logic clk;
  logic reset;
  logic [3:0] req_n;
  logic m0_grnt_;
  logic m1_grnt_;
  logic m2_grnt_;
  logic m3_grnt_;
  logic [3:0] grants;

  int n_checks;
  int n_fail;
  int m_owner;

  bus_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req_  (req_n[0]),
    .m1_req_  (req_n[1]),
    .m2_req_  (req_n[2]),
    .m3_req_  (req_n[3]),
    .m0_grnt_ (m0_grnt_),
    .m1_grnt_ (m1_grnt_),
    .m2_grnt_ (m2_grnt_),
    .m3_grnt_ (m3_grnt_)
  );

  assign grants = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: owner holds while requesting, else scan owner+1..owner+3 mod 4.
  function automatic int model_next(input int own, input logic [3:0] rq_n);
    int idx;
    if (rq_n[own] == 1'b0) return own;
    for (int k = 1; k < 4; k++) begin
      idx = (own + k) % 4;
      if (rq_n[idx] == 1'b0) return idx;
    end
    return own;
  endfunction

  function automatic logic [3:0] exp_grants(input int own);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << own);
  endfunction

  function automatic int count_low(input logic [3:0] g);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) if (g[i] === 1'b0) c++;
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    m_owner = model_next(m_owner, req_n);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_n = 4'b1111;
    m_owner = 0;
    #13;
    n_checks++;
    if (grants !== 4'b1110) begin
      n_fail++;
      $display("FAIL reset_hold: grants=%b expected=%b", grants, 4'b1110);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (grants !== 4'b1110) begin
        n_fail++;
        $display("FAIL reset_idle cyc%0d: grants=%b expected=%b", i, grants, 4'b1110);
      end
    end
  endtask

  task automatic test_sequential();
    logic [3:0] seq_req [4];
    seq_req[0] = 4'b1110;
    seq_req[1] = 4'b1101;
    seq_req[2] = 4'b1011;
    seq_req[3] = 4'b0111;
    req_n = seq_req[0];
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (grants !== 4'b1110) begin
        n_fail++;
        $display("FAIL seq_m0_hold cyc%0d: grants=%b expected=%b", i, grants, 4'b1110);
      end
    end
    for (int s = 1; s < 4; s++) begin
      req_n = seq_req[s];
      #1;
      n_checks++;
      if (grants !== seq_req[s-1]) begin
        n_fail++;
        $display("FAIL seq_before_edge m%0d: grants=%b expected=%b", s, grants, seq_req[s-1]);
      end
      tick();
      n_checks++;
      if (grants !== seq_req[s] || grants !== exp_grants(m_owner)) begin
        n_fail++;
        $display("FAIL seq_handover m%0d: grants=%b expected=%b", s, grants, seq_req[s]);
      end
    end
  endtask

  task automatic test_fairness();
    req_n = 4'b1101;
    tick();
    n_checks++;
    if (grants !== 4'b1101) begin
      n_fail++;
      $display("FAIL fair_setup_m1: grants=%b expected=%b", grants, 4'b1101);
    end
    req_n = 4'b0010;
    tick();
    n_checks++;
    if (grants !== 4'b1011) begin
      n_fail++;
      $display("FAIL fair_1_to_2: grants=%b expected=%b", grants, 4'b1011);
    end
    req_n = 4'b0110;
    tick();
    n_checks++;
    if (grants !== 4'b0111) begin
      n_fail++;
      $display("FAIL fair_2_to_3: grants=%b expected=%b", grants, 4'b0111);
    end
    req_n = 4'b1110;
    tick();
    n_checks++;
    if (grants !== 4'b1110) begin
      n_fail++;
      $display("FAIL fair_3_wrap_0: grants=%b expected=%b", grants, 4'b1110);
    end
  endtask

  task automatic test_hold();
    req_n = 4'b1011;
    tick();
    n_checks++;
    if (grants !== 4'b1011) begin
      n_fail++;
      $display("FAIL hold_setup_m2: grants=%b expected=%b", grants, 4'b1011);
    end
    req_n = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (grants !== 4'b1011) begin
        n_fail++;
        $display("FAIL hold_no_preempt cyc%0d: grants=%b expected=%b", i, grants, 4'b1011);
      end
    end
  endtask

  task automatic test_parking();
    req_n = 4'b0111;
    tick();
    n_checks++;
    if (grants !== 4'b0111) begin
      n_fail++;
      $display("FAIL park_setup_m3: grants=%b expected=%b", grants, 4'b0111);
    end
    req_n = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (grants !== 4'b0111) begin
        n_fail++;
        $display("FAIL park_m3 cyc%0d: grants=%b expected=%b", i, grants, 4'b0111);
      end
    end
    req_n = 4'b1101;
    tick();
    n_checks++;
    if (grants !== 4'b1101) begin
      n_fail++;
      $display("FAIL park_to_m1: grants=%b expected=%b", grants, 4'b1101);
    end
  endtask

  task automatic test_async_reset();
    req_n = 4'b1011;
    tick();
    n_checks++;
    if (grants !== 4'b1011) begin
      n_fail++;
      $display("FAIL areset_setup_m2: grants=%b expected=%b", grants, 4'b1011);
    end
    #2;
    reset = 1'b0;
    m_owner = 0;
    #1;
    n_checks++;
    if (grants !== 4'b1110) begin
      n_fail++;
      $display("FAIL areset_immediate: grants=%b expected=%b", grants, 4'b1110);
    end
    #1;
    reset = 1'b1;
    req_n = 4'b1111;
    #1;
    n_checks++;
    if (grants !== 4'b1110) begin
      n_fail++;
      $display("FAIL areset_after_release: grants=%b expected=%b", grants, 4'b1110);
    end
    tick();
    n_checks++;
    if (grants !== 4'b1110) begin
      n_fail++;
      $display("FAIL areset_first_edge: grants=%b expected=%b", grants, 4'b1110);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req_n = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (grants !== exp_grants(m_owner) || count_low(grants) != 1) begin
        n_fail++;
        $display("FAIL random cyc%0d req_n=%b: grants=%b expected=%b", i, req_n, grants, exp_grants(m_owner));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_sequential();
    test_fairness();
    test_hold();
    test_parking();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
